video_shifter: RTL and testbench

Pixel serializer directly downstream of `video_gen`. It captures the character code and character-ROM pattern that `video_gen` fetches over the shared bus, loads them into an 8-bit shift register at each character boundary, and shifts one pixel out per pixel enable. It applies per-character reverse video, blanking and global invert, and re-times `h_sync`/`v_sync` so they stay aligned with the serialized pixels.

---
 rtl/video_pkg.sv | 14 +
 rtl/strobe_capture.sv | 32 +++
 rtl/video_shifter.sv | 140 ++++++++++++++
 tb/tb_video_shifter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: character-cell geometry and the fetched cell record
// used by both video_gen and video_shifter.
package video_pkg;

    localparam int PIXELS_PER_CHAR = 8;
    localparam int REVERSE_BIT     = 7;
    localparam int PIX_CNT_W       = 3;

    typedef struct packed {
        logic       rev;
        logic [7:0] pattern;
    } char_cell_t;

endpackage

// File: rtl/strobe_capture.sv
// Falling-edge detector plus data latch for one video bus strobe; data_o holds
// the bus value from the last cycle the strobe was high.
module strobe_capture #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              strobe_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              capture_o,
    output logic [DATA_W-1:0] data_o
);

    logic              strobe_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            strobe_q <= 1'b0;
            data_q   <= '0;
        end else begin
            strobe_q <= strobe_i;
            if (strobe_i) begin
                data_q <= data_i;
            end
        end
    end

    assign capture_o = strobe_q & ~strobe_i;
    assign data_o    = data_q;

endmodule

// File: rtl/video_shifter.sv
// Pixel serializer behind video_gen: captures code/pattern fetches, loads the
// shift register at each character boundary and re-times the syncs to match.
module video_shifter #(
    parameter int PIXELS_PER_CHAR = video_pkg::PIXELS_PER_CHAR,
    parameter int REVERSE_BIT     = video_pkg::REVERSE_BIT
) (
    input  logic       clk16_i,
    input  logic       reset_i,
    input  logic       pixel_ce_i,
    input  logic [7:0] bus_data_i,
    input  logic       video_ram_strobe_i,
    input  logic       video_rom_strobe_i,
    input  logic       h_active_i,
    input  logic       v_active_i,
    input  logic       h_sync_i,
    input  logic       v_sync_i,
    input  logic       display_en_i,
    input  logic       invert_i,
    output logic       video_o,
    output logic       h_sync_o,
    output logic       v_sync_o,
    output logic       stale_o
);

    import video_pkg::*;

    logic       ram_cap, rom_cap;
    logic [0:0] ram_rev;
    logic [7:0] rom_pat;

    strobe_capture #(.DATA_W(1)) u_ram_cap (
        .clk_i     (clk16_i),
        .reset_i   (reset_i),
        .strobe_i  (video_ram_strobe_i),
        .data_i    (bus_data_i[REVERSE_BIT]),
        .capture_o (ram_cap),
        .data_o    (ram_rev)
    );

    strobe_capture #(.DATA_W(8)) u_rom_cap (
        .clk_i     (clk16_i),
        .reset_i   (reset_i),
        .strobe_i  (video_rom_strobe_i),
        .data_i    (bus_data_i),
        .capture_o (rom_cap),
        .data_o    (rom_pat)
    );

    char_cell_t           pend_q, pend_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic                 rev_q, rev_d, act_q, act_d;
    logic                 hs_dly_q, hs_dly_d, vs_dly_q, vs_dly_d;
    logic                 fresh_q, fresh_d, stale_q, stale_d;
    logic                 video_q, video_d, hs_out_q, hs_out_d, vs_out_q, vs_out_d;
    logic                 load, act_load;

    assign load     = pixel_ce_i && (pix_cnt_q == PIX_CNT_W'(PIXELS_PER_CHAR - 1));
    assign act_load = h_active_i & v_active_i & display_en_i;

    always_comb begin
        pend_d    = pend_q;
        pix_cnt_d = pix_cnt_q;
        shift_d   = shift_q;
        rev_d     = rev_q;
        act_d     = act_q;
        hs_dly_d  = hs_dly_q;
        vs_dly_d  = vs_dly_q;
        fresh_d   = fresh_q;
        stale_d   = stale_q;
        video_d   = video_q;
        hs_out_d  = hs_out_q;
        vs_out_d  = vs_out_q;

        if (pixel_ce_i) begin
            pix_cnt_d = h_sync_i ? '0 : pix_cnt_q + 1'b1;
            video_d   = ((shift_q[7] ^ rev_q) & act_q) ^ invert_i;
            hs_out_d  = hs_dly_q;
            vs_out_d  = vs_dly_q;
            if (load) begin
                shift_d  = pend_q.pattern;
                rev_d    = pend_q.rev;
                act_d    = act_load;
                hs_dly_d = h_sync_i;
                vs_dly_d = v_sync_i;
                fresh_d  = 1'b0;
                if (!fresh_q && act_load) begin
                    stale_d = 1'b1;
                end
            end else begin
                shift_d = {shift_q[6:0], 1'b0};
            end
        end

        // Captures land after the load has taken the old pending values.
        if (ram_cap) begin
            pend_d.rev = ram_rev[0];
        end
        if (rom_cap) begin
            pend_d.pattern = rom_pat;
            fresh_d        = 1'b1;
        end
    end

    always_ff @(posedge clk16_i) begin
        if (reset_i) begin
            pend_q    <= '0;
            pix_cnt_q <= '0;
            shift_q   <= '0;
            rev_q     <= 1'b0;
            act_q     <= 1'b0;
            hs_dly_q  <= 1'b0;
            vs_dly_q  <= 1'b0;
            fresh_q   <= 1'b0;
            stale_q   <= 1'b0;
            video_q   <= invert_i;
            hs_out_q  <= 1'b0;
            vs_out_q  <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            pix_cnt_q <= pix_cnt_d;
            shift_q   <= shift_d;
            rev_q     <= rev_d;
            act_q     <= act_d;
            hs_dly_q  <= hs_dly_d;
            vs_dly_q  <= vs_dly_d;
            fresh_q   <= fresh_d;
            stale_q   <= stale_d;
            video_q   <= video_d;
            hs_out_q  <= hs_out_d;
            vs_out_q  <= vs_out_d;
        end
    end

    assign video_o  = video_q;
    assign h_sync_o = hs_out_q;
    assign v_sync_o = vs_out_q;
    assign stale_o  = stale_q;

endmodule

// File: tb/tb_video_shifter.sv
// Directed bench for video_shifter: character-block stimulus, a pixel-index
// reference model checked every cycle, and literal per-character expectations.
module tb_video_shifter;

    logic       clk16 = 1'b0;
    logic       reset, pixel_ce, ram_stb, rom_stb, hact, vact, hs, vs, den, inv;
    logic [7:0] bus_data;
    logic       video, hs_o, vs_o, stale;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    logic [7:0] vec, hsv, vsv;

    always #5 clk16 = ~clk16;

    video_shifter dut (
        .clk16_i            (clk16),
        .reset_i            (reset),
        .pixel_ce_i         (pixel_ce),
        .bus_data_i         (bus_data),
        .video_ram_strobe_i (ram_stb),
        .video_rom_strobe_i (rom_stb),
        .h_active_i         (hact),
        .v_active_i         (vact),
        .h_sync_i           (hs),
        .v_sync_i           (vs),
        .display_en_i       (den),
        .invert_i           (inv),
        .video_o            (video),
        .h_sync_o           (hs_o),
        .v_sync_o           (vs_o),
        .stale_o            (stale)
    );

    // Reference model: the current character is held as a whole cell and the
    // output is picked by how many enables have elapsed since it was loaded.
    bit         m_ram_prev, m_rom_prev, m_ram_last_rev;
    logic [7:0] m_rom_last, m_pend_pat, m_cur_pat;
    bit         m_pend_rev, m_cur_rev, m_cur_act, m_fresh, m_stale;
    int         m_cnt, m_idx;
    bit         m_video, m_hs_smp, m_vs_smp, m_hs_out, m_vs_out;

    function automatic bit pix_at(int idx);
        if (idx < 8) return (m_cur_pat[7-idx] ^ m_cur_rev) & m_cur_act;
        return m_cur_rev & m_cur_act;
    endfunction

    always @(posedge clk16) begin
        bit ram_fall, rom_fall, is_load, new_act;
        if (reset) begin
            m_ram_prev = 0; m_rom_prev = 0; m_ram_last_rev = 0; m_rom_last = 0;
            m_pend_pat = 0; m_pend_rev = 0; m_cur_pat = 0; m_cur_rev = 0; m_cur_act = 0;
            m_fresh = 0; m_stale = 0; m_cnt = 0; m_idx = 8;
            m_hs_smp = 0; m_vs_smp = 0; m_hs_out = 0; m_vs_out = 0;
            m_video = inv;
        end else begin
            ram_fall = m_ram_prev && !ram_stb;
            rom_fall = m_rom_prev && !rom_stb;
            is_load  = pixel_ce && (m_cnt == 7);
            if (pixel_ce) begin
                m_video = inv ^ pix_at(m_idx);
                if (m_idx < 8) m_idx++;
                m_hs_out = m_hs_smp;
                m_vs_out = m_vs_smp;
                if (is_load) begin
                    new_act = hact && vact && den;
                    if (new_act && !m_fresh) m_stale = 1;
                    m_cur_pat = m_pend_pat;
                    m_cur_rev = m_pend_rev;
                    m_cur_act = new_act;
                    m_idx     = 0;
                    m_hs_smp  = hs;
                    m_vs_smp  = vs;
                    m_fresh   = 0;
                end
                m_cnt = hs ? 0 : (m_cnt + 1) % 8;
            end
            if (ram_fall) m_pend_rev = m_ram_last_rev;
            if (rom_fall) begin
                m_pend_pat = m_rom_last;
                m_fresh    = 1;
            end
            if (ram_stb) m_ram_last_rev = bus_data[7];
            if (rom_stb) m_rom_last = bus_data;
            m_ram_prev = ram_stb;
            m_rom_prev = rom_stb;
        end
    end

    task automatic cmp1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cmp8(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk16) begin
        #1;
        if (chk_en) begin
            cmp1("model_video", video, m_video);
            cmp1("model_hsync", hs_o, m_hs_out);
            cmp1("model_vsync", vs_o, m_vs_out);
            cmp1("model_stale", stale, m_stale);
        end
    end

    // One character cell: 16 clocks, enables on even clocks, load on clock 14.
    // Pixels of the previous character are recorded MSB-first into vec.
    task automatic run_block(input logic [7:0] pat, input logic [7:0] code,
                             input bit rom_en, input bit late_en, input logic [7:0] late_pat,
                             input bit h_act, input bit d_en, input bit inv_v,
                             input bit hs_load, input bit vs_load, input bit hs_mid,
                             input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk16);
            pixel_ce = (c % 2 == 0);
            ram_stb  = (c == 2 || c == 3);
            rom_stb  = (rom_en && (c == 6 || c == 7)) || (late_en && (c == 12 || c == 13));
            case (c)
                3:       bus_data = code;
                7:       bus_data = pat;
                13:      bus_data = late_pat;
                default: bus_data = 8'($urandom);
            endcase
            hact = h_act;
            vact = 1'b1;
            den  = d_en;
            inv  = inv_v;
            hs   = (hs_load && c == 14) || (hs_mid && c == 6);
            vs   = vs_load && c == 14;
            if (pixel_ce) begin
                @(posedge clk16);
                #1;
                vec[7 - c/2] = video;
                hsv[7 - c/2] = hs_o;
                vsv[7 - c/2] = vs_o;
            end
        end
    endtask

    task automatic do_reset(input bit inv_v, input bit chk);
        @(negedge clk16);
        reset = 1; pixel_ce = 0; ram_stb = 0; rom_stb = 0; hs = 0; vs = 0; inv = inv_v;
        @(posedge clk16);
        #1;
        if (chk) begin
            cmp1("rst_video", video, inv_v);
            cmp1("rst_hsync", hs_o, 1'b0);
            cmp1("rst_vsync", vs_o, 1'b0);
            cmp1("rst_stale", stale, 1'b0);
        end
        @(negedge clk16);
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; pixel_ce = 0; ram_stb = 0; rom_stb = 0; bus_data = 0;
        hact = 0; vact = 0; hs = 0; vs = 0; den = 0; inv = 0;
        do_reset(1'b0, 1'b1);
        chk_en = 1'b1;

        //         pat    code   rom late latep  hact den inv hsL vsL hsM ncyc
        run_block(8'hA5, 8'h01, 1, 0, 8'h00, 1,   1,  0,  0,  0,  0,  16);
        run_block(8'hF0, 8'h81, 1, 0, 8'h00, 1,   1,  0,  0,  0,  0,  16);
        cmp8("basic_a5", vec, 8'hA5);
        run_block(8'hF0, 8'h81, 1, 0, 8'h00, 1,   1,  1,  0,  0,  0,  16);
        cmp8("reverse_inv", vec, 8'hF0);
        run_block(8'hFF, 8'h01, 1, 0, 8'h00, 0,   1,  0,  0,  1,  0,  16);
        cmp8("reverse", vec, 8'h0F);
        cmp8("vsync_before", vsv, 8'h00);
        run_block(8'hFF, 8'h01, 1, 0, 8'h00, 1,   0,  1,  0,  0,  0,  16);
        cmp8("blank_hact_inv", vec, 8'hFF);
        cmp8("vsync_after", vsv, 8'hFF);
        run_block(8'hFF, 8'h01, 1, 0, 8'h00, 1,   1,  0,  1,  0,  0,  16);
        cmp8("blank_den", vec, 8'h00);
        cmp8("hsync_before", hsv, 8'h00);
        run_block(8'hFF, 8'h01, 1, 1, 8'h3C, 1,   1,  0,  0,  0,  0,  16);
        cmp8("pattern_ff", vec, 8'hFF);
        cmp8("hsync_after", hsv, 8'hFF);
        run_block(8'h00, 8'h01, 0, 0, 8'h00, 1,   1,  0,  0,  0,  0,  16);
        cmp8("collision_cur", vec, 8'hFF);
        cmp1("collision_no_stale", stale, 1'b0);
        run_block(8'h00, 8'h01, 0, 0, 8'h00, 1,   1,  0,  0,  0,  0,  16);
        cmp8("collision_next", vec, 8'h3C);
        cmp1("stale_set", stale, 1'b1);
        run_block(8'h66, 8'h01, 1, 0, 8'h00, 1,   1,  0,  0,  0,  0,  16);
        cmp8("stale_repeat", vec, 8'h3C);
        cmp1("stale_sticky", stale, 1'b1);
        run_block(8'h66, 8'h01, 1, 0, 8'h00, 1,   1,  0,  0,  0,  0,  5);
        do_reset(1'b0, 1'b1);
        run_block(8'h5A, 8'h01, 1, 0, 8'h00, 1,   1,  0,  0,  0,  0,  16);
        cmp8("post_reset_blank", vec, 8'h00);
        run_block(8'hC3, 8'h01, 1, 0, 8'h00, 1,   1,  0,  0,  0,  0,  16);
        cmp8("post_reset_char", vec, 8'h5A);
        run_block(8'h81, 8'h80, 1, 0, 8'h00, 1,   1,  0,  0,  0,  1,  16);
        run_block(8'h3C, 8'h01, 1, 0, 8'h00, 1,   1,  0,  0,  0,  0,  16);
        run_block(8'h99, 8'h81, 1, 0, 8'h00, 1,   1,  1,  0,  0,  0,  16);
        run_block(8'h00, 8'h01, 0, 0, 8'h00, 1,   1,  0,  0,  0,  0,  16);

        @(negedge clk16);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
